// File: rtl/priority_encoder_bank.sv
// priority_encoder_bank: registered 16->4, 8->3 and 4->2 highest-bit priority encoders with valid flags.
module priority_encoder_bank (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        EN,
    input  logic [15:0] IN,
    output logic [3:0]  OUT4,
    output logic [2:0]  OUT3,
    output logic [1:0]  OUT2,
    output logic        VALID16,
    output logic        VALID8,
    output logic        VALID4
);
    function automatic logic [1:0] enc4(input logic [3:0] v);
        return v[3] ? 2'd3 : v[2] ? 2'd2 : v[1] ? 2'd1 : 2'd0;
    endfunction

    // Wider encoders pick the upper half when it has any request, else fall through to the lower half.
    function automatic logic [2:0] enc8(input logic [7:0] v);
        return |v[7:4] ? {1'b1, enc4(v[7:4])} : {1'b0, enc4(v[3:0])};
    endfunction

    function automatic logic [3:0] enc16(input logic [15:0] v);
        return |v[15:8] ? {1'b1, enc8(v[15:8])} : {1'b0, enc8(v[7:0])};
    endfunction

    logic [3:0] out4_d, out4_q;
    logic [2:0] out3_d, out3_q;
    logic [1:0] out2_d, out2_q;
    logic       valid16_d, valid16_q;
    logic       valid8_d, valid8_q;
    logic       valid4_d, valid4_q;

    always_comb begin
        out4_d    = EN ? enc16(IN)   : out4_q;
        out3_d    = EN ? enc8(IN[7:0]) : out3_q;
        out2_d    = EN ? enc4(IN[3:0]) : out2_q;
        valid16_d = EN ? |IN         : valid16_q;
        valid8_d  = EN ? |IN[7:0]    : valid8_q;
        valid4_d  = EN ? |IN[3:0]    : valid4_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            out4_q    <= 4'd0;
            out3_q    <= 3'd0;
            out2_q    <= 2'd0;
            valid16_q <= 1'b0;
            valid8_q  <= 1'b0;
            valid4_q  <= 1'b0;
        end else begin
            out4_q    <= out4_d;
            out3_q    <= out3_d;
            out2_q    <= out2_d;
            valid16_q <= valid16_d;
            valid8_q  <= valid8_d;
            valid4_q  <= valid4_d;
        end
    end

    assign OUT4    = out4_q;
    assign OUT3    = out3_q;
    assign OUT2    = out2_q;
    assign VALID16 = valid16_q;
    assign VALID8  = valid8_q;
    assign VALID4  = valid4_q;
endmodule

// File: tb/tb_priority_encoder_bank.sv
// tb_priority_encoder_bank: directed vector table plus exhaustive sweep, checked through an expected-result queue.
module tb_priority_encoder_bank;
    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic        EN = 1'b0;
    logic [15:0] IN = 16'h0000;
    logic [3:0]  OUT4;
    logic [2:0]  OUT3;
    logic [1:0]  OUT2;
    logic        VALID16, VALID8, VALID4;

    priority_encoder_bank dut (
        .CLK(clk), .RESET(RESET), .EN(EN), .IN(IN),
        .OUT4(OUT4), .OUT3(OUT3), .OUT2(OUT2),
        .VALID16(VALID16), .VALID8(VALID8), .VALID4(VALID4)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] o4;
        logic [2:0] o3;
        logic [1:0] o2;
        logic       v16, v8, v4;
    } exp_t;

    typedef struct {
        logic        rst, en;
        logic [15:0] in;
        exp_t        x;
    } vec_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic exp_t mk(string tag, int o4, int o3, int o2, bit v16, bit v8, bit v4);
        exp_t e;
        e.tag = tag; e.o4 = 4'(o4); e.o3 = 3'(o3); e.o2 = 2'(o2);
        e.v16 = v16; e.v8 = v8; e.v4 = v4;
        return e;
    endfunction

    function automatic vec_t mv(bit r, bit e, logic [15:0] d, exp_t x);
        vec_t v;
        v.rst = r; v.en = e; v.in = d; v.x = x;
        return v;
    endfunction

    // Reference: scan upward, last set bit seen in each slice is the winner.
    function automatic exp_t model(logic [15:0] d);
        exp_t e;
        e = mk("exh", 0, 0, 0, |d, |d[7:0], |d[3:0]);
        for (int i = 0; i < 16; i++)
            if (d[i]) begin
                e.o4 = 4'(i);
                if (i < 8) e.o3 = 3'(i);
                if (i < 4) e.o2 = 2'(i);
            end
        return e;
    endfunction

    task automatic check_pending();
        exp_t x;
        if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            n_checks++;
            if ({OUT4, OUT3, OUT2, VALID16, VALID8, VALID4} !== {x.o4, x.o3, x.o2, x.v16, x.v8, x.v4}) begin
                n_fail++;
                $display("FAIL %s IN_prev got OUT4=%0d OUT3=%0d OUT2=%0d V=%b%b%b expected OUT4=%0d OUT3=%0d OUT2=%0d V=%b%b%b",
                         x.tag, OUT4, OUT3, OUT2, VALID16, VALID8, VALID4, x.o4, x.o3, x.o2, x.v16, x.v8, x.v4);
            end
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [15:0] d, input exp_t x);
        @(negedge clk);
        check_pending();
        RESET = r; EN = e; IN = d;
        exp_q.push_back(x);
        cur = x;
    endtask

    initial begin
        exp_t h;
        tbl.push_back(mv(1, 1, 16'hFFFF, mk("reset0", 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mv(1, 1, 16'hFFFF, mk("reset1", 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mv(0, 1, 16'hFFFF, mk("reset_rel", 15, 7, 3, 1, 1, 1)));
        tbl.push_back(mv(0, 1, 16'h0000, mk("zero", 0, 0, 0, 0, 0, 0)));
        for (int k = 0; k < 16; k++)
            tbl.push_back(mv(0, 1, 16'(1 << k), mk($sformatf("onehot%0d", k), k, k < 8 ? k : 0, k < 4 ? k : 0, 1, k < 8, k < 4)));
        tbl.push_back(mv(0, 1, 16'h8001, mk("prio8001", 15, 0, 0, 1, 1, 1)));
        tbl.push_back(mv(0, 1, 16'h0101, mk("prio0101", 8, 0, 0, 1, 1, 1)));
        tbl.push_back(mv(0, 1, 16'h0003, mk("prio0003", 1, 1, 1, 1, 1, 1)));
        tbl.push_back(mv(0, 1, 16'h0040, mk("en_cap", 6, 6, 0, 1, 1, 0)));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mv(0, 0, 16'h0002, mk($sformatf("en_hold%0d", k), 6, 6, 0, 1, 1, 0)));
        tbl.push_back(mv(0, 1, 16'h0002, mk("en_rise", 1, 1, 1, 1, 1, 1)));
        tbl.push_back(mv(0, 1, 16'h4000, mk("stream0", 14, 0, 0, 1, 0, 0)));
        tbl.push_back(mv(1, 1, 16'h4000, mk("rst_mid", 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mv(0, 1, 16'h4000, mk("rst_rel", 14, 0, 0, 1, 0, 0)));
        tbl.push_back(mv(1, 0, 16'hFFFF, mk("rst_en0", 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mv(0, 1, 16'h0900, mk("pre_pulse", 11, 0, 0, 1, 0, 0)));

        foreach (tbl[i]) drive(tbl[i].rst, tbl[i].en, tbl[i].in, tbl[i].x);

        // A reset pulse between edges must not disturb the held outputs.
        h = cur;
        h.tag = "mid_pulse";
        drive(0, 0, 16'h0005, h);
        #2 RESET = 1'b1;
        #1 RESET = 1'b0;
        IN = 16'hF00F;

        for (int i = 0; i < 65536; i++) drive(0, 1, 16'(i), model(16'(i)));
        @(negedge clk);
        check_pending();
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
